// File: rtl/elevator_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler_pkg
// Brief    : Shared state encoding, default timing constants and width
//            helpers for the elevator car controller and its consumers.
// Revision : 1.0 - initial release
// ============================================================================
package elevator_scheduler_pkg;

    // State encoding is also decoded by the display and VGA blocks.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MOVE = 2'b01,
        ST_DOOR = 2'b10,
        ST_RSVD = 2'b11
    } state_t;

    localparam int unsigned C_DEF_FLOORS     = 4;
    localparam int unsigned C_DEF_MOVE_TICKS = 100_000_000;
    localparam int unsigned C_DEF_DOOR_TICKS = 200_000_000;

    // Floor index width; never narrower than one bit.
    function automatic int unsigned f_floor_width(input int unsigned floors);
        return (floors > 1) ? int'($clog2(floors)) : 1;
    endfunction

    // Timer width able to hold the larger reload value (ticks - 1).
    function automatic int unsigned f_timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 2) ? int'($clog2(m)) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler_if
// Brief    : Call-button input and car status outputs of the elevator
//            controller. slave = controller side, master = user/display side.
// Revision : 1.0 - initial release
// ============================================================================
interface elevator_scheduler_if
    import elevator_scheduler_pkg::*;
#(
    parameter int unsigned FLOORS = C_DEF_FLOORS
);
    localparam int unsigned FW = f_floor_width(FLOORS);

    logic [FLOORS-1:0] call_req;
    logic [FW-1:0]     cur_floor;
    logic              dir_up;
    logic              moving;
    logic              door_open;
    logic [FLOORS-1:0] pending;
    logic [1:0]        state;

    modport master (
        output call_req,
        input  cur_floor, dir_up, moving, door_open, pending, state
    );

    modport slave (
        input  call_req,
        output cur_floor, dir_up, moving, door_open, pending, state
    );

endinterface

`default_nettype wire

// File: rtl/elevator_call_latch.sv
`default_nettype none
// ============================================================================
// Module   : elevator_call_latch
// Brief    : Rising-edge detect on the call buttons and the pending-call
//            register. Clear beats set; absorbed edges never set a bit.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_call_latch
    import elevator_scheduler_pkg::*;
#(
    parameter int unsigned FLOORS = C_DEF_FLOORS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] call_req,
    input  logic [FLOORS-1:0] clr_vec,
    input  logic [FLOORS-1:0] absorb_vec,
    output logic [FLOORS-1:0] pending
);

    logic [FLOORS-1:0] r_call_q;
    logic [FLOORS-1:0] r_pending;
    logic [FLOORS-1:0] w_rise;

    assign w_rise  = call_req & ~r_call_q;
    assign pending = r_pending;

    // Edge-detect history and pending set/clear (clear has priority).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_call_q  <= '0;
            r_pending <= '0;
        end else begin
            r_call_q  <= call_req;
            r_pending <= (r_pending | (w_rise & ~absorb_vec)) & ~clr_vec;
        end
    end

endmodule

`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Brief    : Elevator car controller. SCAN direction choice, per-floor
//            travel timer and door dwell timer; registered status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int unsigned FLOORS     = C_DEF_FLOORS,
    parameter int unsigned MOVE_TICKS = C_DEF_MOVE_TICKS,
    parameter int unsigned DOOR_TICKS = C_DEF_DOOR_TICKS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    elevator_scheduler_if.slave  bus
);

    localparam int unsigned FW = f_floor_width(FLOORS);
    localparam int unsigned TW = f_timer_width(MOVE_TICKS, DOOR_TICKS);

    localparam logic [TW-1:0] C_MOVE_LOAD = TW'(MOVE_TICKS - 1);
    localparam logic [TW-1:0] C_DOOR_LOAD = TW'(DOOR_TICKS - 1);
    localparam logic [FW-1:0] C_TOP_FLOOR = FW'(FLOORS - 1);

    state_t            r_state;
    logic [FW-1:0]     r_floor;
    logic              r_up;
    logic [TW-1:0]     r_timer;
    logic              r_moving;
    logic              r_door;
    logic [FLOORS-1:0] r_call_q;

    state_t            w_state_nxt;
    logic [FW-1:0]     w_floor_nxt;
    logic              w_up_nxt;
    logic [TW-1:0]     w_timer_nxt;
    logic [FLOORS-1:0] w_clr_vec;
    logic [FLOORS-1:0] w_absorb_vec;
    logic [FLOORS-1:0] w_pending;

    logic [FW-1:0]     w_target;
    logic [FLOORS-1:0] w_here_vec;
    logic [FLOORS-1:0] w_tgt_vec;
    logic              w_above;
    logic              w_below;
    logic              w_tgt_ahead;
    logic              w_here_call;
    logic              w_tgt_call;
    logic              w_rise_here;
    logic              w_new_up;
    logic              w_at_limit;

    elevator_call_latch #(
        .FLOORS (FLOORS)
    ) u_call_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .call_req   (bus.call_req),
        .clr_vec    (w_clr_vec),
        .absorb_vec (w_absorb_vec),
        .pending    (w_pending)
    );

    // Neighbouring floor in the current direction; wrap is caught by w_at_limit.
    assign w_target   = r_up ? (r_floor + FW'(1)) : (r_floor - FW'(1));
    assign w_at_limit = r_up ? (r_floor == C_TOP_FLOOR) : (r_floor == '0);

    // One-hot floor decode and pending-call summaries around the car.
    always_comb begin
        w_here_vec  = '0;
        w_tgt_vec   = '0;
        w_above     = 1'b0;
        w_below     = 1'b0;
        w_tgt_ahead = 1'b0;
        for (int i = 0; i < int'(FLOORS); i++) begin
            w_here_vec[i] = (i == int'(r_floor));
            w_tgt_vec[i]  = (i == int'(w_target));
            if (i > int'(r_floor)) w_above = w_above | w_pending[i];
            if (i < int'(r_floor)) w_below = w_below | w_pending[i];
            if (r_up ? (i > int'(w_target)) : (i < int'(w_target)))
                w_tgt_ahead = w_tgt_ahead | w_pending[i];
        end
    end

    assign w_here_call = |(w_pending & w_here_vec);
    assign w_tgt_call  = |(w_pending & w_tgt_vec);
    assign w_rise_here = |(bus.call_req & ~r_call_q & w_here_vec);
    // SCAN: keep heading while calls lie ahead, reverse only if all are behind.
    assign w_new_up    = r_up ? (w_above | ~w_below) : (w_above & ~w_below);

    // Next-state, timer and floor decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_up_nxt     = r_up;
        w_timer_nxt  = r_timer;
        w_clr_vec    = '0;
        w_absorb_vec = (r_state == ST_DOOR) ? w_here_vec : '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_pending) begin
                    if (w_here_call) begin
                        w_state_nxt = ST_DOOR;
                        w_clr_vec   = w_here_vec;
                        w_timer_nxt = C_DOOR_LOAD;
                    end else begin
                        w_up_nxt    = w_new_up;
                        w_state_nxt = ST_MOVE;
                        w_timer_nxt = C_MOVE_LOAD;
                    end
                end
            end
            ST_MOVE: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - TW'(1);
                end else if (w_at_limit) begin
                    // Defensive: never step past the building's ends.
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_floor_nxt = w_target;
                    if (w_tgt_call) begin
                        w_state_nxt = ST_DOOR;
                        w_clr_vec   = w_tgt_vec;
                        w_timer_nxt = C_DOOR_LOAD;
                    end else if (w_tgt_ahead) begin
                        w_timer_nxt = C_MOVE_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                // A fresh press at this floor holds the door open again.
                if (w_rise_here) begin
                    w_timer_nxt = C_DOOR_LOAD;
                end else if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller state, timer and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_floor  <= '0;
            r_up     <= 1'b1;
            r_timer  <= '0;
            r_moving <= 1'b0;
            r_door   <= 1'b0;
            r_call_q <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_floor  <= w_floor_nxt;
            r_up     <= w_up_nxt;
            r_timer  <= w_timer_nxt;
            r_moving <= (w_state_nxt == ST_MOVE);
            r_door   <= (w_state_nxt == ST_DOOR);
            r_call_q <= bus.call_req;
        end
    end

    assign bus.state     = r_state;
    assign bus.cur_floor = r_floor;
    assign bus.dir_up    = r_up;
    assign bus.moving    = r_moving;
    assign bus.door_open = r_door;
    assign bus.pending   = w_pending;

endmodule

`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scheduler
// Brief    : Self-checking bench for elevator_scheduler with a cycle-level
//            behavioural model of the car (FLOORS=4, MOVE=4, DOOR=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

    localparam int NF = 4;
    localparam int MT = 4;
    localparam int DT = 3;
    // {state, cur_floor, dir_up, moving, door_open, pending} after reset
    localparam logic [10:0] C_RST = {2'b00, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    elevator_scheduler_if #(.FLOORS(NF)) bus ();

    elevator_scheduler #(
        .FLOORS     (NF),
        .MOVE_TICKS (MT),
        .DOOR_TICKS (DT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 travelling, 2 door open; left = cycles left in segment
    typedef struct {
        int          mode;
        int          floor;
        bit          up;
        bit [NF-1:0] pend;
        bit [NF-1:0] prev;
        int          left;
    } model_t;

    model_t m;

    function automatic bit calls_above(bit [NF-1:0] p, int f);
        for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit calls_below(bit [NF-1:0] p, int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.floor = 0; r.up = 1'b1; r.pend = '0; r.prev = '0; r.left = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, bit [NF-1:0] req);
        model_t      n;
        bit [NF-1:0] rise, setm, clrm;
        int          nf;
        n    = c;
        rise = req & ~c.prev;
        setm = rise;
        clrm = '0;
        n.prev = req;
        case (c.mode)
            0: if (c.pend != 0) begin
                if (c.pend[c.floor]) begin
                    n.mode = 2; clrm[c.floor] = 1'b1; n.left = DT;
                end else begin
                    if (c.up ? (!calls_above(c.pend, c.floor) && calls_below(c.pend, c.floor))
                             : (!calls_below(c.pend, c.floor) && calls_above(c.pend, c.floor)))
                        n.up = !c.up;
                    n.mode = 1; n.left = MT;
                end
            end
            1: begin
                n.left = c.left - 1;
                if (n.left == 0) begin
                    nf = c.up ? c.floor + 1 : c.floor - 1;
                    if (nf < 0 || nf >= NF) begin
                        n.mode = 0;
                    end else begin
                        n.floor = nf;
                        if (c.pend[nf]) begin
                            n.mode = 2; clrm[nf] = 1'b1; n.left = DT;
                        end else if (c.up ? calls_above(c.pend, nf) : calls_below(c.pend, nf)) begin
                            n.left = MT;
                        end else begin
                            n.mode = 0;
                        end
                    end
                end
            end
            default: begin
                setm[c.floor] = 1'b0;
                if (rise[c.floor]) n.left = DT;
                else begin
                    n.left = c.left - 1;
                    if (n.left == 0) n.mode = 0;
                end
            end
        endcase
        n.pend = (c.pend | setm) & ~clrm;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_step(m, bus.call_req);
    end

    function automatic logic [10:0] obs();
        return {bus.state, bus.cur_floor, bus.dir_up, bus.moving, bus.door_open, bus.pending};
    endfunction

    function automatic logic [10:0] expv();
        return {2'(m.mode), 2'(m.floor), m.up, (m.mode == 1), (m.mode == 2), 4'(m.pend)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        bus.call_req = '0;
        repeat (3) @(negedge clk);
        total++;
        if (obs() !== C_RST) begin bad++; $display("FAIL reset_state: dut=%b want=%b", obs(), C_RST); end
        rst_n = 1'b1;
        @(negedge clk);
        bus.call_req = 4'b1000;
        n = 0;
        do begin
            @(negedge clk);
            bus.call_req = '0;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_reset_run: dut=%b model=%b", obs(), expv()); end
            n++;
        end while (!(bus.cur_floor == 2'd1 && bus.moving) && n < 40);
        total++;
        if (n >= 40) begin bad++; $display("FAIL reset_reach_floor1: cycles=%0d limit=40", n); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== C_RST) begin bad++; $display("FAIL reset_async_midmove: dut=%b want=%b", obs(), C_RST); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_call();
        bus.call_req = 4'b0100;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            bus.call_req = '0;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_single k=%0d: dut=%b model=%b", k, obs(), expv()); end
            if (k == 1) begin
                total++;
                if (bus.pending !== 4'b0100 || bus.state !== 2'b00)
                    begin bad++; $display("FAIL single_pending_set: pend=%b st=%b want 0100/00", bus.pending, bus.state); end
            end
            if (k == 5) begin
                total++;
                if (bus.cur_floor !== 2'd0 || bus.moving !== 1'b1)
                    begin bad++; $display("FAIL single_floor0_still: floor=%0d mv=%b want 0/1", bus.cur_floor, bus.moving); end
            end
            if (k == 6) begin
                total++;
                if (bus.cur_floor !== 2'd1 || bus.moving !== 1'b1)
                    begin bad++; $display("FAIL single_floor1: floor=%0d mv=%b want 1/1", bus.cur_floor, bus.moving); end
            end
            if (k == 10) begin
                total++;
                if ({bus.state, bus.cur_floor, bus.door_open, bus.pending} !== {2'b10, 2'd2, 1'b1, 4'b0000})
                    begin bad++; $display("FAIL single_door_floor2: got=%b want=%b",
                        {bus.state, bus.cur_floor, bus.door_open, bus.pending}, {2'b10, 2'd2, 1'b1, 4'b0000}); end
            end
            if (k == 12) begin
                total++;
                if (bus.door_open !== 1'b1) begin bad++; $display("FAIL single_door_dwell: door=%b want 1", bus.door_open); end
            end
            if (k == 13) begin
                total++;
                if (bus.state !== 2'b00 || bus.door_open !== 1'b0)
                    begin bad++; $display("FAIL single_back_idle: st=%b door=%b want 00/0", bus.state, bus.door_open); end
            end
        end
    endtask

    task automatic test_scan();
        int q[$];
        int n;
        bit seen3;
        logic prev_door;
        // car at floor 2 idle: first go down to floor 1
        bus.call_req = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            bus.call_req = '0;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_scan_setup: dut=%b model=%b", obs(), expv()); end
            n++;
        end while (!(bus.state == 2'b00 && bus.pending == '0) && n < 60);
        total++;
        if (n >= 60) begin bad++; $display("FAIL scan_setup_timeout: cycles=%0d limit=60", n); end
        bus.call_req = 4'b1000;
        seen3 = 1'b0;
        prev_door = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_scan: dut=%b model=%b", obs(), expv()); end
            if (n >= 1 && !seen3) begin
                total++;
                if (bus.dir_up !== 1'b1) begin bad++; $display("FAIL scan_dir_early: dir_up=%b want 1 at n=%0d", bus.dir_up, n); end
            end
            if (bus.door_open && !prev_door) begin
                q.push_back(int'(bus.cur_floor));
                if (bus.cur_floor == 2'd3) seen3 = 1'b1;
            end
            prev_door = bus.door_open;
            bus.call_req = (n == 2) ? 4'b0101 : 4'b0000;
            n++;
        end while (!(n > 4 && bus.state == 2'b00 && bus.pending == '0) && n < 150);
        total++;
        if (n >= 150) begin bad++; $display("FAIL scan_timeout: cycles=%0d limit=150", n); end
        total++;
        if (!(q.size() == 3 && q[0] == 2 && q[1] == 3 && q[2] == 0))
            begin bad++; $display("FAIL scan_stop_order: stops=%p want '{2,3,0}", q); end
        total++;
        if (bus.dir_up !== 1'b0 || bus.cur_floor !== 2'd0)
            begin bad++; $display("FAIL scan_final: dir_up=%b floor=%0d want 0/0", bus.dir_up, bus.cur_floor); end
    endtask

    task automatic test_same_floor();
        int n;
        bus.call_req = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            bus.call_req = '0;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_same_setup: dut=%b model=%b", obs(), expv()); end
            n++;
        end while (!(bus.state == 2'b00 && bus.pending == '0) && n < 40);
        total++;
        if (n >= 40) begin bad++; $display("FAIL same_setup_timeout: cycles=%0d limit=40", n); end
        bus.call_req = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.call_req = '0;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_same k=%0d: dut=%b model=%b", k, obs(), expv()); end
            total++;
            if (bus.moving !== 1'b0 || bus.cur_floor !== 2'd1)
                begin bad++; $display("FAIL same_no_move k=%0d: mv=%b floor=%0d want 0/1", k, bus.moving, bus.cur_floor); end
            if (k == 1) begin
                total++;
                if (bus.pending !== 4'b0010 || bus.state !== 2'b00)
                    begin bad++; $display("FAIL same_pending: pend=%b st=%b want 0010/00", bus.pending, bus.state); end
            end
            if (k == 2) begin
                total++;
                if (bus.state !== 2'b10 || bus.door_open !== 1'b1 || bus.pending !== 4'b0000)
                    begin bad++; $display("FAIL same_door: st=%b door=%b pend=%b want 10/1/0000", bus.state, bus.door_open, bus.pending); end
            end
            if (k == 5) begin
                total++;
                if (bus.state !== 2'b00 || bus.door_open !== 1'b0)
                    begin bad++; $display("FAIL same_close: st=%b door=%b want 00/0", bus.state, bus.door_open); end
            end
        end
    endtask

    task automatic test_door_extend();
        int n;
        bus.call_req = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            bus.call_req = '0;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_ext_setup: dut=%b model=%b", obs(), expv()); end
            n++;
        end while (!bus.door_open && n < 30);
        total++;
        if (n >= 30) begin bad++; $display("FAIL ext_setup_timeout: cycles=%0d limit=30", n); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_ext k=%0d: dut=%b model=%b", k, obs(), expv()); end
            total++;
            if (k <= 5 && (bus.door_open !== 1'b1 || bus.pending[2] !== 1'b0))
                begin bad++; $display("FAIL ext_held k=%0d: door=%b pend2=%b want 1/0", k, bus.door_open, bus.pending[2]); end
            else if (k == 6 && (bus.door_open !== 1'b0 || bus.state !== 2'b00))
                begin bad++; $display("FAIL ext_close: door=%b st=%b want 0/00", bus.door_open, bus.state); end
            bus.call_req = (k == 2) ? 4'b0100 : 4'b0000;
        end
    endtask

    task automatic test_held_call();
        int n;
        bit seen3;
        seen3 = 1'b0;
        bus.call_req = 4'b1000;
        n = 0;
        do begin
            @(negedge clk);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_held: dut=%b model=%b", obs(), expv()); end
            if (bus.door_open && bus.cur_floor == 2'd3) seen3 = 1'b1;
            n++;
        end while (!(seen3 && bus.state == 2'b00) && n < 40);
        total++;
        if (n >= 40) begin bad++; $display("FAIL held_timeout: cycles=%0d limit=40", n); end
        repeat (5) begin
            @(negedge clk);
            total++;
            if (bus.pending !== 4'b0000 || bus.state !== 2'b00)
                begin bad++; $display("FAIL held_no_recall: pend=%b st=%b want 0000/00", bus.pending, bus.state); end
        end
        bus.call_req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            bus.call_req = '0;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_held_leave: dut=%b model=%b", obs(), expv()); end
            n++;
        end while (!bus.moving && n < 10);
        total++;
        if (n >= 10) begin bad++; $display("FAIL held_leave_timeout: cycles=%0d limit=10", n); end
        bus.call_req = 4'b1000;
        @(negedge clk);
        bus.call_req = '0;
        total++;
        if (bus.pending !== 4'b1001) begin bad++; $display("FAIL held_new_edge: pend=%b want 1001", bus.pending); end
        n = 0;
        do begin
            @(negedge clk);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_held_drain: dut=%b model=%b", obs(), expv()); end
            n++;
        end while (!(bus.state == 2'b00 && bus.pending == '0) && n < 200);
        total++;
        if (n >= 200) begin bad++; $display("FAIL held_drain_timeout: cycles=%0d limit=200", n); end
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_random c=%0d: dut=%b model=%b", c, obs(), expv()); end
            for (int b = 0; b < NF; b++)
                if ($urandom_range(0, 9) == 0) bus.call_req[b] = ~bus.call_req[b];
        end
        bus.call_req = '0;
        n = 0;
        do begin
            @(negedge clk);
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL model_random_drain: dut=%b model=%b", obs(), expv()); end
            n++;
        end while (!(bus.state == 2'b00 && bus.pending == '0) && n < 300);
        total++;
        if (n >= 300) begin bad++; $display("FAIL random_drain_timeout: cycles=%0d limit=300", n); end
    endtask

    initial begin
        bus.call_req = '0;
        test_reset();
        test_single_call();
        test_scan();
        test_same_floor();
        test_door_extend();
        test_held_call();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
